// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Programmable serial-pattern detection controller. A pattern of 1..PAT_W
//   bits, a length, an overlap policy and a match limit are loaded while idle.
//   A run then shifts qualified serial bits into a history register, pulses
//   `match` once per detected occurrence, and counts matches. The run stops
//   when the programmed limit is reached, or when `abort` is asserted.
//
// Ports
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   cfg_valid    config offer (pattern/len/overlap/limit qualified)
//   cfg_ready    config accept, high only in IDLE
//   cfg_pattern  pattern bits, bit[len-1] oldest, bit[0] newest
//   cfg_len      pattern length, 0 = invalid, >PAT_W clamps to PAT_W
//   cfg_overlap  1 = overlapping matches, 0 = history restarts after a match
//   cfg_limit    stop after this many matches, 0 = unlimited
//   start        begin a run (pulse)
//   abort        return to IDLE, highest priority
//   bit_valid    qualifies bit_in
//   bit_in       serial data bit
//   match        one-cycle pulse per match
//   match_count  saturating match counter for the current/last run
//   busy         high in RUN
//   done         high in DONE
//   state_o      IDLE=0, RUN=1, DONE=2
`timescale 1ns/1ps
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]       PAT_W_L = 4'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [PAT_W-1:0]   pat_reg, pat_next;
    logic [3:0]         len_reg, len_next;
    logic               ovl_reg, ovl_next;
    logic [CNT_W-1:0]   lim_reg, lim_next;
    logic [PAT_W-1:0]   hist_reg, hist_next;
    logic [3:0]         fill_reg, fill_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               match_reg, match_next;

    logic               cfg_take;
    logic [3:0]         cfg_len_clamped;
    logic [3:0]         eff_len;
    logic [PAT_W-1:0]   hist_shift;
    logic [3:0]         fill_inc;
    logic [PAT_W-1:0]   len_mask;
    logic               hit;
    logic [CNT_W-1:0]   count_inc;

    // Compare only the low len bits of the history against the pattern.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign len_mask[gi] = (4'(gi) < len_reg);
        end
    endgenerate

    assign cfg_take        = cfg_valid && (state_reg == ST_IDLE);
    assign cfg_len_clamped = (cfg_len > PAT_W_L) ? PAT_W_L : cfg_len;
    // A config offered together with start governs that start.
    assign eff_len         = cfg_take ? cfg_len_clamped : len_reg;

    assign hist_shift = (hist_reg << 1) | PAT_W'(bit_in);
    assign fill_inc   = (fill_reg >= PAT_W_L) ? PAT_W_L : fill_reg + 4'd1;
    assign hit        = (fill_inc >= len_reg) &&
                        (((hist_shift ^ pat_reg) & len_mask) == '0);
    assign count_inc  = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        len_next   = len_reg;
        ovl_next   = ovl_reg;
        lim_next   = lim_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        count_next = count_reg;
        match_next = 1'b0;

        if (cfg_take) begin
            pat_next = cfg_pattern;
            len_next = cfg_len_clamped;
            ovl_next = cfg_overlap;
            lim_next = cfg_limit;
        end

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && (eff_len != 4'd0)) begin
                        state_next = ST_RUN;
                        hist_next  = '0;
                        fill_next  = 4'd0;
                        count_next = '0;
                    end
                end
                ST_RUN: begin
                    if (bit_valid) begin
                        hist_next = hist_shift;
                        fill_next = fill_inc;
                        if (hit) begin
                            match_next = 1'b1;
                            count_next = count_inc;
                            // Non-overlapping: the next match needs len fresh bits.
                            if (!ovl_reg) begin
                                fill_next = 4'd0;
                            end
                            if ((lim_reg != '0) && (count_inc == lim_reg)) begin
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_next = ST_RUN;
                        hist_next  = '0;
                        fill_next  = 4'd0;
                        count_next = '0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= ST_IDLE;
            pat_reg   <= '0;
            len_reg   <= 4'd0;
            ovl_reg   <= 1'b0;
            lim_reg   <= '0;
            hist_reg  <= '0;
            fill_reg  <= 4'd0;
            count_reg <= '0;
            match_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            len_reg   <= len_next;
            ovl_reg   <= ovl_next;
            lim_reg   <= lim_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            count_reg <= count_next;
            match_reg <= match_next;
        end
    end

    // Every output is a register or a decode of the state register only.
    assign cfg_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_DONE);
    assign state_o     = state_reg;
    assign match       = match_reg;
    assign match_count = count_reg;

endmodule
